// File: rtl/pipe_hazard_ctrl.sv
// Purpose : stall/flush sequencer for the 5-stage pipeline (load-use, branch redirect, MDU handshake + timeout).
// Latency : stall/flush/go outputs are combinational from state and inputs; state, timeout and counters update on posedge.
// Backpr. : the MDU holds F/D/E stalled until mdu_done or timeout; a load-use hazard holds F/D for one bubble per hazard cycle.
module pipe_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int TMO   = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic [REG_W-1:0] rd_e,
    input  logic             mem_read_e,
    input  logic             pc_src_e,
    input  logic             mdu_start_e,
    input  logic             mdu_done,
    input  logic             perf_clr,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             mdu_go,
    output logic             mdu_busy,
    output logic             mdu_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int TW = (TMO > 2) ? $clog2(TMO) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [TW-1:0] tmo;
    logic          hazard;
    logic          tmo_hit;

    // Load-use: a load in E writing a register that D reads; x0 is hardwired and never conflicts.
    assign hazard  = mem_read_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign tmo_hit = (tmo == TMO_LAST);

    // Pipeline control decode; everything is held low while reset is asserted.
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        mdu_go   = 1'b0;
        mdu_busy = 1'b0;
        if (!reset) begin
            if (state == BUSY) begin
                mdu_busy = 1'b1;
                if (!mdu_done) begin
                    // On timeout the front end is released, but the hung op in E
                    // is still bubbled so no garbage result reaches M.
                    flush_m = 1'b1;
                    if (!tmo_hit) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                    end
                end
            end else if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (mdu_start_e) begin
                mdu_go  = 1'b1;
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else if (hazard) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // MDU handshake FSM with BUSY-cycle timeout and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tmo     <= '0;
            mdu_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!pc_src_e && mdu_start_e) begin
                        state <= BUSY;
                        tmo   <= '0;
                    end
                end
                BUSY: begin
                    if (mdu_done) begin
                        state <= IDLE;
                    end else if (tmo_hit) begin
                        state   <= IDLE;
                        mdu_err <= 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating stall-cycle counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || perf_clr) begin
            stall_cnt <= '0;
        end else if (stall_f && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and clear inputs of the F/D/E/M pipeline registers, which are synchronous-reset flops with a clear input.
- Detects load-use hazards and taken-branch redirects.
- Runs a multi-cycle handshake with the mul/div unit (MDU), including a timeout, and keeps a saturating stall-cycle performance counter.

Parameters:
- REG_W, 5, register-index width.
- TMO, 64, maximum BUSY cycles before the MDU is declared hung (must be ≥2).
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- rs1_d  in  REG_W  source register 1 of the instruction in D.
- rs2_d  in  REG_W  source register 2 of the instruction in D.
- rd_e  in  REG_W  destination register of the instruction in E.
- mem_read_e  in  1  instruction in E is a load.
- pc_src_e  in  1  taken branch/jump resolved in E.
- mdu_start_e  in  1  instruction in E is a multi-cycle MDU op.
- mdu_done  in  1  MDU result valid (1-cycle pulse).
- perf_clr  in  1  clear the stall counter.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold the F/D register.
- stall_e  out  1  hold the D/E register.
- flush_d  out  1  clear the F/D register.
- flush_e  out  1  clear the D/E register.
- flush_m  out  1  clear the E/M register (bubble).
- mdu_go  out  1  start pulse to the MDU.
- mdu_busy  out  1  FSM is in BUSY.
- mdu_err  out  1  sticky MDU timeout flag.
- stall_cnt  out  CNT_W  count of stalled cycles.

Behaviour:
- Reset:
  - While reset=1, all control outputs are forced to 0.
  - Next-cycle state: IDLE; tmo counter 0, stall_cnt 0, mdu_err 0.
  - A reset in BUSY aborts without mdu_go or error.
- FSM states: IDLE and BUSY. Outputs are combinational from state and inputs; state and counters are registered.
- IDLE, priority high to low:
  1. pc_src_e=1: flush_d=1, flush_e=1, all stalls 0. mdu_start_e and the load-use hazard are ignored.
  2. mdu_start_e=1: mdu_go=1, stall_f=stall_d=stall_e=1, flush_m=1. Next state BUSY, tmo=0.
  3. Load-use hazard, defined as mem_read_e & (rd_e≠0) & (rd_e==rs1_d | rd_e==rs2_d): stall_f=stall_d=1, flush_e=1. This gives exactly one bubble, with no extra cycle unless the hazard persists.
  4. Otherwise all outputs are 0.
- BUSY:
  - mdu_busy=1.
  - pc_src_e, mem_read_e and mdu_start_e are ignored (pipeline frozen, E holds the MDU op).
  - mdu_done=0 and tmo<TMO-1: stall_f=stall_d=stall_e=1, flush_m=1; tmo increments.
  - mdu_done=1: all stalls and flushes are 0 this cycle, so E/M captures the result. Next state IDLE. Done wins over timeout in the same cycle.
  - mdu_done=0 and tmo==TMO-1: stalls are 0 this cycle, mdu_err is set (sticky until reset), next state IDLE.
  - mdu_done is not sampled in IDLE. A stray done pulse is ignored.
  - Minimum MDU latency is 1 cycle after mdu_go.
- stall_cnt:
  - Increments by 1 on every cycle with stall_f=1.
  - Saturates at 2^CNT_W−1 and does not wrap.
  - perf_clr=1 clears it to 0 and takes priority over an increment in the same cycle.
- Register 0 never causes a hazard.
- mdu_go is high for exactly one cycle per MDU op.

Test Plan:
- Load-use bubble: mem_read_e=1, rd_e=5, rs2_d=5 for 1 cycle → stall_f=stall_d=flush_e=1 for that cycle only; stall_cnt=1. Repeat with rd_e=0 → no stall.
- Branch plus hazard: pc_src_e=1 with the load-use condition true → flush_d=flush_e=1, stall_f=0, stall_cnt unchanged.
- MDU 3-cycle op: mdu_start_e at cycle 0, mdu_done at cycle 3 → mdu_go only at cycle 0; stalls and flush_m at cycles 0–2; all 0 at cycle 3; mdu_busy at cycles 1–3; stall_cnt=3.
- Timeout: TMO=4, mdu_start_e pulsed, no mdu_done → stalls on the go cycle plus 3 BUSY cycles, released on the 4th BUSY cycle; mdu_err=1 and stays 1; next op still works.
- Counter saturation: CNT_W=4, hold the hazard for 20 cycles → stall_cnt stops at 15. perf_clr together with the hazard → 0.
- Reset mid-op: reset during BUSY cycle 2 → outputs 0 while reset is high; state IDLE, mdu_err=0, stall_cnt=0 after reset.
